// File: rtl/fifo_drain_mc.sv
// fifo_drain_mc: round-robin multi-channel FIFO drain engine with ap_ctrl start/ready/done/idle handshake.
// Optional watchdog on stalled channels is compiled in with `define FIFO_DRAIN_TIMEOUT_EN.
module fifo_drain_mc #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [31:0]          size,
    input  logic [31:0]          times,
    input  logic [NCH-1:0]       ch_mask,
    output logic [NCH-1:0]       fifo_rd_en,
    input  logic [NCH*WIDTH-1:0] fifo_rd_data,
    input  logic [NCH-1:0]       fifo_empty,
    input  logic                 ap_start,
    output logic                 ap_idle,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic [WIDTH-1:0]     checksum,
    output logic [31:0]          word_count,
    output logic                 err_timeout
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;
    state_t state;

    logic [31:0]    size_r;
    logic [31:0]    times_r;
    logic [NCH-1:0] mask_r;
    logic [31:0]    word_cnt;
    logic [31:0]    pass_cnt;
    logic [CW-1:0]  ch;
    logic           rd;
    logic           burst_end;
    logic           last_pass;
    logic           degenerate;
    logic           wd_fire;
    logic [CW:0]    nxt;
    logic           vld_p1;
    logic [CW-1:0]  sel_p1;

    // Returns {found, index} of the first enabled channel strictly above cur.
    function automatic logic [CW:0] next_above(input logic [NCH-1:0] m, input logic [CW-1:0] cur);
        logic [CW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i] && (i > int'(cur))) r = {1'b1, CW'(i)};
        return r;
    endfunction

    function automatic logic [CW-1:0] lowest(input logic [NCH-1:0] m);
        logic [CW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (m[i]) r = CW'(i);
        return r;
    endfunction

    assign rd         = (state == DRAIN) && !fifo_empty[ch];
    assign burst_end  = rd && (word_cnt == size_r - 32'd1);
    assign last_pass  = (pass_cnt == times_r - 32'd1);
    assign degenerate = (size == 32'd0) || (times == 32'd0) || (ch_mask == '0);
    assign nxt        = next_above(mask_r, ch);

    assign ap_idle  = (state == IDLE) && !ap_start;
    assign ap_ready = (state == IDLE) && ap_start;
    assign ap_done  = (state == FINISH);

    always_comb begin
        fifo_rd_en = '0;
        if (rd && !ap_rst) fifo_rd_en[ch] = 1'b1;
    end

`ifdef FIFO_DRAIN_TIMEOUT_EN
    logic [31:0] wd_cnt;

    assign wd_fire = (state == DRAIN) && !rd && (wd_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst || state != DRAIN || rd) wd_cnt <= '0;
        else                                wd_cnt <= wd_cnt + 32'd1;
    end
`else
    // Watchdog compiled out; TIMEOUT is referenced only so the parameter list stays uniform.
    assign wd_fire = 1'b0 && (TIMEOUT != 0);
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            vld_p1      <= 1'b0;
            checksum    <= '0;
            word_count  <= '0;
            err_timeout <= 1'b0;
        end else begin
            // p1: FIFO data arrives one cycle after the strobe
            vld_p1 <= rd;
            sel_p1 <= ch;
            if (vld_p1) begin
                checksum   <= checksum ^ fifo_rd_data[sel_p1*WIDTH +: WIDTH];
                word_count <= word_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (ap_start) begin
                        size_r      <= size;
                        times_r     <= times;
                        mask_r      <= ch_mask;
                        ch          <= lowest(ch_mask);
                        word_cnt    <= '0;
                        pass_cnt    <= '0;
                        checksum    <= '0;
                        word_count  <= '0;
                        err_timeout <= 1'b0;
                        state       <= degenerate ? FINISH : DRAIN;
                    end
                end
                DRAIN: begin
                    if (wd_fire) begin
                        err_timeout <= 1'b1;
                        state       <= FINISH;
                    end else if (rd) begin
                        if (!burst_end) begin
                            word_cnt <= word_cnt + 32'd1;
                        end else begin
                            word_cnt <= '0;
                            if (nxt[CW]) begin
                                ch <= nxt[CW-1:0];
                            end else begin
                                ch       <= lowest(mask_r);
                                pass_cnt <= pass_cnt + 32'd1;
                                if (last_pass) state <= FINISH;
                            end
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_drain_mc.sv
// tb_fifo_drain_mc: directed and randomized jobs for fifo_drain_mc checked against a queue-based
// model of the expected read order, done timing and checksum.
module tb_fifo_drain_mc;
    localparam int WIDTH = 8;
    localparam int NCH   = 2;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst = 1'b1;
    logic [31:0]          size = '0;
    logic [31:0]          times = '0;
    logic [NCH-1:0]       ch_mask = '0;
    logic [NCH-1:0]       fifo_rd_en;
    logic [NCH*WIDTH-1:0] fifo_rd_data = '0;
    logic [NCH-1:0]       fifo_empty = '0;
    logic                 ap_start = 1'b0;
    logic                 ap_idle;
    logic                 ap_ready;
    logic                 ap_done;
    logic [WIDTH-1:0]     checksum;
    logic [31:0]          word_count;
    logic                 err_timeout;

    always #5 ap_clk = ~ap_clk;

    fifo_drain_mc #(.WIDTH(WIDTH), .NCH(NCH), .TIMEOUT(16)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .size(size), .times(times), .ch_mask(ch_mask),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .ap_start(ap_start), .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
        .checksum(checksum), .word_count(word_count), .err_timeout(err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] fdat [NCH][64];
    int done_cyc;
    logic [NCH-1:0] rd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One job: cycle 0 is the ap_ready cycle; the model walks the expected channel sequence.
    task automatic run_job(input int sz, input int tm, input logic [NCH-1:0] mk, input bit dir_data,
                           input int pct, input int st_ch, input int st_after, input int st_len,
                           input logic [NCH-1:0] dead, input int rst_at, input bit busy_start);
        int order[$];
        int idx, run, left, fptr[NCH], cnt[NCH];
        bit fin, exp_err, trig;
        logic [NCH-1:0] emp, exp_rd, prev_rd;
        logic [WIDTH-1:0] exp_cs;

        order = {};
        for (int p = 0; p < tm; p++)
            for (int c = 0; c < NCH; c++)
                if (mk[c])
                    for (int w = 0; w < sz; w++) order.push_back(c);
        for (int c = 0; c < NCH; c++) begin
            fptr[c] = 0;
            cnt[c]  = 0;
            for (int i = 0; i < 64; i++)
                fdat[c][i] = dir_data ? ((c == 0) ? 8'(i + 1) : 8'(16 + i)) : 8'($urandom);
        end
        idx = 0; run = 0; left = 0; trig = 0; exp_err = 0;
        fin = (order.size() == 0);
        done_cyc = -1;
        rd_seen = '0;
        prev_rd = '0;

        @(posedge ap_clk); #1;
        size = 32'(sz); times = 32'(tm); ch_mask = mk; ap_start = 1'b1; fifo_empty = dead;
        @(negedge ap_clk);
        chk("start_ready", 32'(ap_ready), 1);
        chk("start_idle", 32'(ap_idle), 0);
        chk("start_rd_en", 32'(fifo_rd_en), 0);
        @(posedge ap_clk); #1;
        ap_start = 1'b0; size = $urandom; times = $urandom; ch_mask = NCH'($urandom);

        for (int cyc = 1; cyc <= 600; cyc++) begin
            for (int c = 0; c < NCH; c++)
                if (prev_rd[c]) begin
                    fifo_rd_data[c*WIDTH +: WIDTH] = fdat[c][fptr[c]];
                    fptr[c]++;
                end
            if (!trig && st_len > 0 && cnt[st_ch] >= st_after) begin
                trig = 1;
                left = st_len;
            end
            emp = dead;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(99) < 32'(pct)) emp[c] = 1'b1;
            if (left > 0) begin
                emp[st_ch] = 1'b1;
                left--;
            end
            fifo_empty = emp;
            if (busy_start) ap_start = 1'($urandom_range(1));
            if (cyc == rst_at) ap_rst = 1'b1;
            exp_rd = '0;
            if (!fin && !emp[order[idx]]) exp_rd[order[idx]] = 1'b1;

            @(negedge ap_clk);
            if (cyc == rst_at) begin
                chk("rst_rd_en_forced", 32'(fifo_rd_en), 0);
                @(posedge ap_clk); #1;
                ap_rst = 1'b0; ap_start = 1'b0;
                @(negedge ap_clk);
                chk("rst_idle", 32'(ap_idle), 1);
                chk("rst_word_count", word_count, 0);
                chk("rst_checksum", 32'(checksum), 0);
                chk("rst_done", 32'(ap_done), 0);
                return;
            end
            chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            chk("done", 32'(ap_done), 32'(fin));
            chk("ready_busy", 32'(ap_ready), 0);
            chk("idle_busy", 32'(ap_idle), 0);
            rd_seen |= fifo_rd_en;
            if (fin) begin
                done_cyc = cyc;
                break;
            end
            if (exp_rd != '0) begin
                cnt[order[idx]]++;
                idx++;
                run = 0;
                if (idx == order.size()) fin = 1;
            end else begin
                run++;
`ifdef FIFO_DRAIN_TIMEOUT_EN
                if (run == 16) begin
                    fin = 1;
                    exp_err = 1;
                end
`endif
            end
            prev_rd = fifo_rd_en;
            @(posedge ap_clk); #1;
        end
        chk("job_done_seen", 32'(done_cyc >= 0), 1);

        exp_cs = '0;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < cnt[c]; i++) exp_cs ^= fdat[c][i];
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        @(negedge ap_clk);
        chk("post_idle", 32'(ap_idle), 1);
        chk("post_done", 32'(ap_done), 0);
        chk("post_checksum", 32'(checksum), 32'(exp_cs));
        chk("post_word_count", word_count, 32'(idx));
        chk("post_err_timeout", 32'(err_timeout), 32'(exp_err));
    endtask

    initial begin
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("reset_idle", 32'(ap_idle), 1);
        chk("reset_ready", 32'(ap_ready), 0);
        chk("reset_done", 32'(ap_done), 0);
        chk("reset_rd_en", 32'(fifo_rd_en), 0);
        chk("reset_checksum", 32'(checksum), 0);
        chk("reset_word_count", word_count, 0);
        chk("reset_err", 32'(err_timeout), 0);

        // Full two-channel job
        run_job(4, 2, 2'b11, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("full_done_cycle", 32'(done_cyc), 17);
        chk("full_word_count", word_count, 16);
        chk("full_checksum", 32'(checksum), 32'h08);

        // Masked channel
        run_job(3, 1, 2'b10, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("mask_done_cycle", 32'(done_cyc), 4);
        chk("mask_ch0_never", 32'(rd_seen[0]), 0);
        chk("mask_word_count", word_count, 3);

        // Stall on ch0 for 5 cycles after its 2nd read
        run_job(4, 2, 2'b11, 1, 0, 0, 2, 5, 2'b00, 0, 0);
        chk("stall_done_cycle", 32'(done_cyc), 22);
        chk("stall_checksum", 32'(checksum), 32'h08);

        // Degenerate jobs
        run_job(0, 2, 2'b11, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("degen_done_cycle", 32'(done_cyc), 1);
        chk("degen_no_reads", 32'(rd_seen), 0);
        chk("degen_word_count", word_count, 0);
        run_job(3, 0, 2'b01, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("degen_times_done", 32'(done_cyc), 1);
        run_job(3, 1, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("degen_mask_done", 32'(done_cyc), 1);

        // Reset mid-drain, then a normal job
        run_job(4, 2, 2'b11, 1, 0, 0, 0, 0, 2'b00, 6, 0);
        run_job(4, 2, 2'b11, 1, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("after_rst_done_cycle", 32'(done_cyc), 17);
        chk("after_rst_checksum", 32'(checksum), 32'h08);

`ifdef FIFO_DRAIN_TIMEOUT_EN
        // Watchdog: ch1 never supplies data
        run_job(4, 1, 2'b11, 1, 0, 0, 0, 0, 2'b10, 0, 0);
        chk("wd_done_cycle", 32'(done_cyc), 21);
        chk("wd_err", 32'(err_timeout), 1);
        chk("wd_word_count", word_count, 4);
`endif

        // Randomized jobs with random empties and busy-time start requests
        for (int j = 0; j < 10; j++)
            run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    0, 30, 0, 0, 0, 2'b00, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
